sigdel_decim: RTL



---
 rtl/sigdel_decim.sv | 60 ++++++
 1 files changed

// File: rtl/sigdel_decim.sv
// sigdel_decim: sinc2 CIC decimator turning a 1-bit sigma-delta stream into saturated OUT_W-bit PCM
module sigdel_decim #(
  parameter int DEC_LOG2 = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  output logic             sat
);
  localparam int W = 2*DEC_LOG2+1;
  localparam int SH = 2*DEC_LOG2-OUT_W;
  logic [W-1:0] i1, i2, d1, d2, i2_n, c1, c2, y;
  logic [DEC_LOG2-1:0] phase;
  logic [1:0] warm;
  logic clamp;
  always_comb begin
    i2_n = i2 + i1;
    c1 = i2_n - d1;
    c2 = c1 - d2;
    y = c2 >> SH;
    clamp = |y[W-1:OUT_W];
  end
  // Modulo-2^W wrap in the integrators cancels in the combs, so it is never checked
  always_ff @(posedge clk) begin
    if (rst) begin
      i1 <= '0;
      i2 <= '0;
      d1 <= '0;
      d2 <= '0;
      phase <= '0;
      warm <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      sat <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      sat <= 1'b0;
      if (en) begin
        i1 <= i1 + {{(W-1){1'b0}}, din};
        i2 <= i2_n;
        phase <= phase + DEC_LOG2'(1);
        if (&phase) begin
          d1 <= i2_n;
          d2 <= c1;
          if (warm == 2'd3) begin
            dout <= clamp ? '1 : y[OUT_W-1:0];
            dout_valid <= 1'b1;
            sat <= clamp;
          end else begin
            warm <= warm + 2'd1;
          end
        end
      end
    end
  end
endmodule
